// File: rtl/conv_mac_unit_pkg.sv
// Shared types and helpers for the CNN multiply-accumulate datapath:
// FSM state encoding, parameter derivations and signed saturation.
package cnn_pkg;

  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_REQUANT = 2'd2,
    ST_OUTPUT  = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    sat;
  } sat_result_t;

  function automatic int calc_kk(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

  function automatic int calc_ch_w(input int max_ch);
    return $clog2(max_ch + 1);
  endfunction

  // Clips value into the signed range of 'width' bits; sat flags a change.
  function automatic sat_result_t sat_signed(input logic signed [SAT_W-1:0] value,
                                             input int width);
    sat_result_t res;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
    lo = ~hi;
    res.value = value;
    res.sat   = 1'b0;
    if (value > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (value < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_unit_if.sv
// Beat input and result output handshake bundle of the MAC unit.
interface conv_mac_unit_if #(
  parameter int WIDTH = 8,
  parameter int KK    = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic [KK*WIDTH-1:0]     in_data;
  logic [KK*WIDTH-1:0]     in_weights;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_value;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, in_weights, out_ready,
    input  in_ready, out_valid, out_value, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_weights, out_ready,
    output in_ready, out_valid, out_value, out_sat
  );
endinterface

// File: rtl/conv_mac_unit_mac_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// then signed saturation to the output width.
module mac_requant
  import cnn_pkg::*;
#(
  parameter int ACCM_WIDTH = 24,
  parameter int WIDTH      = 8,
  parameter int SHIFT_W    = $clog2(ACCM_WIDTH)
) (
  input  logic signed [ACCM_WIDTH-1:0] acc,
  input  logic        [SHIFT_W-1:0]    q_shift,
  input  logic                         relu,
  output logic signed [WIDTH-1:0]      value,
  output logic                         sat
);

  logic signed [ACCM_WIDTH:0] acc_ext;
  logic signed [ACCM_WIDTH:0] rnd;
  logic signed [ACCM_WIDTH:0] rounded;
  logic signed [SAT_W-1:0]    r;
  sat_result_t                res;

  // One extra bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    acc_ext = {acc[ACCM_WIDTH-1], acc};
    rnd     = '0;
    if (q_shift != '0) begin
      rnd = (ACCM_WIDTH+1)'(1) << (q_shift - SHIFT_W'(1));
    end
    rounded = (acc_ext + rnd) >>> q_shift;
    r       = SAT_W'(rounded);
    if (relu && (r < 0)) begin
      r = '0;
    end
    res   = sat_signed(r, WIDTH);
    value = WIDTH'(res.value);
    sat   = res.sat;
  end

endmodule

// File: rtl/conv_mac_unit.sv
// Handshaked multi-channel window MAC: bias + sum of per-channel dot
// products, then requantized to one WIDTH-bit result per job.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for first beat; latches config and bias on accept
// ST_ACCUM   | accepting remaining channel beats into acc
// ST_REQUANT | registers the requantized result of acc
// ST_OUTPUT  | result presented until the consumer takes it
module conv_mac_unit
  import cnn_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int ACCM_WIDTH  = 24,
  parameter  int KERNEL_SIZE = 3,
  parameter  int MAX_CH      = 64,
  localparam int KK          = calc_kk(KERNEL_SIZE),
  localparam int CH_W        = calc_ch_w(MAX_CH),
  localparam int SHIFT_W     = $clog2(ACCM_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic        [CH_W-1:0]       cfg_n_ch,
  input  logic        [SHIFT_W-1:0]    cfg_q_shift,
  input  logic                         cfg_relu,
  input  logic signed [ACCM_WIDTH-1:0] cfg_bias,
  conv_mac_unit_if.slave               bus
);

  mac_state_e                  state_q, state_d;
  logic signed [ACCM_WIDTH-1:0] acc_q, acc_d;
  logic        [CH_W-1:0]       cnt_q, cnt_d;
  logic        [CH_W-1:0]       n_ch_q, n_ch_d;
  logic        [SHIFT_W-1:0]    q_shift_q, q_shift_d;
  logic                         relu_q, relu_d;
  logic signed [WIDTH-1:0]      out_value_q, out_value_d;
  logic                         out_sat_q, out_sat_d;
  logic                         out_valid_q, out_valid_d;
  logic                         in_ready_q, in_ready_d;

  logic                         in_xfer;
  logic        [CH_W-1:0]       eff_n_ch;
  logic signed [ACCM_WIDTH-1:0] dot;
  logic signed [WIDTH-1:0]      elem_d, elem_w;
  logic signed [2*WIDTH-1:0]    prod;
  logic signed [WIDTH-1:0]      rq_value;
  logic                         rq_sat;

  assign in_xfer = bus.in_valid && in_ready_q;

  always_comb begin
    dot    = '0;
    elem_d = '0;
    elem_w = '0;
    prod   = '0;
    for (int i = 0; i < KK; i++) begin
      elem_d = bus.in_data[i*WIDTH +: WIDTH];
      elem_w = bus.in_weights[i*WIDTH +: WIDTH];
      prod   = elem_d * elem_w;
      dot    = dot + ACCM_WIDTH'(prod);
    end
  end

  always_comb begin
    if (cfg_n_ch == '0) begin
      eff_n_ch = CH_W'(1);
    end else if (cfg_n_ch > CH_W'(MAX_CH)) begin
      eff_n_ch = CH_W'(MAX_CH);
    end else begin
      eff_n_ch = cfg_n_ch;
    end
  end

  mac_requant #(
    .ACCM_WIDTH(ACCM_WIDTH),
    .WIDTH     (WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_requant (
    .acc    (acc_q),
    .q_shift(q_shift_q),
    .relu   (relu_q),
    .value  (rq_value),
    .sat    (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_ch_d      = n_ch_q;
    q_shift_d   = q_shift_q;
    relu_d      = relu_q;
    out_value_d = out_value_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          acc_d     = cfg_bias + dot;
          cnt_d     = CH_W'(1);
          n_ch_d    = eff_n_ch;
          q_shift_d = cfg_q_shift;
          relu_d    = cfg_relu;
          state_d   = (eff_n_ch == CH_W'(1)) ? ST_REQUANT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_xfer) begin
          acc_d = acc_q + dot;
          cnt_d = cnt_q + CH_W'(1);
          if (cnt_d == n_ch_q) begin
            state_d = ST_REQUANT;
          end
        end
      end
      ST_REQUANT: begin
        out_value_d = rq_value;
        out_sat_d   = rq_sat;
        state_d     = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags follow the next state so they are clean registers.
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_ch_q      <= CH_W'(1);
      q_shift_q   <= '0;
      relu_q      <= 1'b0;
      out_value_q <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_ch_q      <= n_ch_d;
      q_shift_q   <= q_shift_d;
      relu_q      <= relu_d;
      out_value_q <= out_value_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit: reset, basic job, saturation, rounding,
// ReLU, multi-channel gaps, config isolation, backpressure, mid-job reset.
module tb_conv_mac_unit;
  import cnn_pkg::*;

  localparam int W    = 8;
  localparam int AW   = 24;
  localparam int KK   = 9;
  localparam int CH_W = 7;
  localparam int SH_W = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [CH_W-1:0]      cfg_n_ch;
  logic [SH_W-1:0]      cfg_q_shift;
  logic                 cfg_relu;
  logic signed [AW-1:0] cfg_bias;

  int n_cmp  = 0;
  int n_fail = 0;

  conv_mac_unit_if #(.WIDTH(W), .KK(KK)) bus ();

  conv_mac_unit #(
    .WIDTH(W), .ACCM_WIDTH(AW), .KERNEL_SIZE(3), .MAX_CH(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_n_ch   (cfg_n_ch),
    .cfg_q_shift(cfg_q_shift),
    .cfg_relu   (cfg_relu),
    .cfg_bias   (cfg_bias),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input int dval, input int wval, input int nel);
    for (int i = 0; i < KK; i++) begin
      bus.in_data[i*W +: W]    = (i < nel) ? W'(dval) : '0;
      bus.in_weights[i*W +: W] = (i < nel) ? W'(wval) : '0;
    end
  endtask

  task automatic send_beat(input int dval, input int wval, input int nel, output bit ok);
    load_beat(dval, wval, nel);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      ok = bus.in_ready;
      step();
      if (ok) break;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic set_cfg(input int n, input int bias, input int shift, input bit relu);
    cfg_n_ch    = CH_W'(n);
    cfg_bias    = AW'(bias);
    cfg_q_shift = SH_W'(shift);
    cfg_relu    = relu;
  endtask

  // Single-beat job with out_ready high; returns the presented result.
  task automatic run_job(input int n, input int dval, input int wval, input int bias,
                         input int shift, input bit relu,
                         output logic [W-1:0] v, output logic s, output bit ok);
    bit ok1, ok2;
    set_cfg(n, bias, shift, relu);
    send_beat(dval, wval, KK, ok1);
    wait_out(ok2);
    v  = bus.out_value;
    s  = bus.out_sat;
    ok = ok1 && ok2;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_value !== 8'h00) begin n_fail++; $display("FAIL reset_out_value got=%h exp=00", bus.out_value); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
  endtask

  task automatic test_basic();
    bit ok;
    set_cfg(1, 0, 0, 1'b0);
    send_beat(2, 1, KK, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept got=%b exp=1", ok); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_requant_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_requant_ready got=%b exp=0", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.out_value !== 8'd18) begin n_fail++; $display("FAIL basic_value got=%0d exp=18", bus.out_value); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b exp=0", bus.out_sat); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_after_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] v; logic s; bit ok;
    run_job(1, 127, 127, 0, 0, 1'b0, v, s, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_pos_done got=%b exp=1", ok); end
    n_cmp++; if (v !== 8'h7F) begin n_fail++; $display("FAIL sat_pos_value got=%h exp=7f", v); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got=%b exp=1", s); end
    run_job(1, 127, -128, 0, 0, 1'b0, v, s, ok);
    n_cmp++; if (v !== 8'h80) begin n_fail++; $display("FAIL sat_neg_value got=%h exp=80", v); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag got=%b exp=1", s); end
  endtask

  task automatic test_round_relu();
    logic [W-1:0] v; logic s; bit ok;
    run_job(1, 2, 1, 0, 2, 1'b0, v, s, ok);
    n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL round_pos got=%h exp=05", v); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL round_pos_sat got=%b exp=0", s); end
    run_job(1, -2, 1, 0, 2, 1'b0, v, s, ok);
    n_cmp++; if (v !== 8'hFC) begin n_fail++; $display("FAIL round_neg got=%h exp=fc", v); end
    run_job(1, -2, 1, 0, 2, 1'b1, v, s, ok);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL relu_value got=%h exp=00", v); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL relu_sat got=%b exp=0", s); end
    // n_ch of zero behaves as a single-channel job
    run_job(0, 3, -1, 0, 0, 1'b0, v, s, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL nch0_done got=%b exp=1", ok); end
    n_cmp++; if (v !== 8'hE5) begin n_fail++; $display("FAIL nch0_value got=%h exp=e5", v); end
  endtask

  task automatic test_multi_gaps();
    bit ok; bit okw;
    set_cfg(3, 10, 0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      send_beat(2, 1, KK, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL multi_accept beat=%0d got=%b exp=1", b, ok); end
      if (b == 0) set_cfg(1, 1000, 3, 1'b1);
      if (b < 2) begin
        for (int g = 0; g < 2; g++) begin
          n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL multi_gap_ready beat=%0d got=%b exp=1", b, bus.in_ready); end
          n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_gap_valid beat=%0d got=%b exp=0", b, bus.out_valid); end
          step();
        end
      end
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL multi_end_ready got=%b exp=0", bus.in_ready); end
    wait_out(okw);
    n_cmp++; if (okw !== 1'b1) begin n_fail++; $display("FAIL multi_done got=%b exp=1", okw); end
    n_cmp++; if (bus.out_value !== 8'd64) begin n_fail++; $display("FAIL multi_value got=%0d exp=64", bus.out_value); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL multi_sat got=%b exp=0", bus.out_sat); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    set_cfg(1, 0, 0, 1'b0);
    bus.out_ready = 1'b0;
    send_beat(-2, 1, KK, ok);
    wait_out(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%b exp=1", ok); end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
      n_cmp++; if (bus.out_value !== 8'hEE) begin n_fail++; $display("FAIL bp_value cyc=%0d got=%h exp=ee", c, bus.out_value); end
      n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL bp_sat cyc=%0d got=%b exp=0", c, bus.out_sat); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_xfer got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_job();
    logic [W-1:0] v; logic s; bit ok;
    set_cfg(3, 5, 0, 1'b0);
    send_beat(2, 1, KK, ok);
    send_beat(2, 1, KK, ok);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.in_ready); end
    run_job(1, 2, 1, 0, 0, 1'b0, v, s, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_done got=%b exp=1", ok); end
    n_cmp++; if (v !== 8'd18) begin n_fail++; $display("FAIL midrst_value got=%0d exp=18", v); end
  endtask

  task automatic test_clamp();
    bit ok; bit all_ok;
    set_cfg(100, 0, 0, 1'b0);
    all_ok = 1'b1;
    for (int b = 0; b < 64; b++) begin
      send_beat(1, 1, 1, ok);
      all_ok = all_ok && ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL clamp_accept got=%b exp=1", all_ok); end
    wait_out(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL clamp_done got=%b exp=1", ok); end
    n_cmp++; if (bus.out_value !== 8'd64) begin n_fail++; $display("FAIL clamp_value got=%0d exp=64", bus.out_value); end
    step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_data    = '0;
    bus.in_weights = '0;
    set_cfg(1, 0, 0, 1'b0);
    test_reset();
    test_basic();
    test_saturation();
    test_round_relu();
    test_multi_gaps();
    test_backpressure();
    test_reset_mid_job();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
